spi_dac_multi: RTL and testbench



---
 rtl/spi_dac_pkg.sv | 22 ++
 rtl/spi_dac_clkgen.sv | 34 +++
 rtl/spi_dac_multi.sv | 213 +++++++++++++++++++++
 tb/tb_spi_dac_multi.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_dac_pkg.sv
// Shared types and frame assembly for the multi-channel SPI DAC driver.
package spi_dac_pkg;

   localparam int FRAME_W  = 24;
   localparam int GAP_BITS = 1;

   typedef logic [3:0] cmd_t;
   typedef logic [3:0] addr_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_NEXT_CH,
      ST_CS_GAP,
      ST_SHIFT,
      ST_END
   } state_t;

   function automatic logic [FRAME_W-1:0] make_frame(cmd_t cmd, addr_t addr, logic [15:0] data);
      return {cmd, addr, data};
   endfunction

endpackage

// File: rtl/spi_dac_clkgen.sv
// SCK half-period timer: pulses rise/fall enables every CLK_DIV clk while run is high.
module spi_dac_clkgen #(
   parameter int CLK_DIV = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic run,
   output logic rise,
   output logic fall
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic [CW-1:0] cnt;
   logic          phase;
   logic          tick;

   always_ff @(posedge clk) begin
      if (reset || !run) begin
         cnt   <= CW'(CLK_DIV - 1);
         phase <= 1'b0;
      end else if (cnt == '0) begin
         cnt   <= CW'(CLK_DIV - 1);
         phase <= ~phase;
      end else begin
         cnt <= cnt - CW'(1);
      end
   end

   assign tick = run && (cnt == '0);
   assign rise = tick && !phase;
   assign fall = tick && phase;

endmodule

// File: rtl/spi_dac_multi.sv
// Multi-channel LTC2624-class DAC writer: latches all samples on load, sends one 24-bit frame per channel.
// Optional SPI_DAC_MULTI_SKIP_UNCHANGED_EN skips channels whose value matches the last one written.
//
// state      | meaning
// IDLE       | waiting for load
// NEXT_CH    | scan start, pick first channel to send
// CS_GAP     | CS high for one bit period, shift register loaded
// SHIFT      | CS low, 24 bits clocked out
// END        | done pulse, restart from pending buffer if set
module spi_dac_multi
   import spi_dac_pkg::*;
#(
   parameter int   NUM_CH  = 4,
   parameter int   DATA_W  = 12,
   parameter int   CLK_DIV = 1,
   parameter cmd_t CMD     = 4'b0011
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_CH*DATA_W-1:0] data_in,
   input  logic                     load,
   output logic                     busy,
   output logic                     done,
   output logic                     spi_sck,
   output logic                     spi_sdo,
   output logic                     spi_dac_cs
);

   state_t                   state, state_nx;
   addr_t                    idx, idx_nx, sel;
   logic [4:0]               bit_cnt, bit_cnt_nx;
   logic [NUM_CH*DATA_W-1:0] shadow, pend_data;
   logic                     pend;
   logic [FRAME_W-1:0]       shift_q;
   logic                     run, rise, fall, sck_int, found;
   logic [DATA_W-1:0]        chan_val;
   logic [15:0]              chan_data;

   assign run       = (state == ST_CS_GAP) || (state == ST_SHIFT);
   assign chan_val  = shadow[int'(idx)*DATA_W +: DATA_W];
   assign chan_data = 16'(chan_val) << (16 - DATA_W);
   assign done      = (state == ST_END);

   spi_dac_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
      .clk   (clk),
      .reset (reset),
      .run   (run),
      .rise  (rise),
      .fall  (fall)
   );

`ifdef SPI_DAC_MULTI_SKIP_UNCHANGED_EN
   logic [NUM_CH*DATA_W-1:0] last;
   logic [NUM_CH-1:0]        valid;
   logic                     sent;
   addr_t                    scan_from;

   always_ff @(posedge clk) begin
      if (reset) begin
         last  <= '0;
         valid <= '0;
         sent  <= 1'b0;
      end else begin
         if (state == ST_NEXT_CH)
            sent <= 1'b0;
         else if (state == ST_CS_GAP)
            sent <= 1'b1;
         if (state == ST_SHIFT && fall && bit_cnt == '0) begin
            last[int'(idx)*DATA_W +: DATA_W] <= chan_val;
            valid[int'(idx)]                 <= 1'b1;
         end
      end
   end

   // Lowest channel at or after scan_from whose shadow differs from what the DAC holds.
   always_comb begin
      found     = 1'b0;
      sel       = '0;
      scan_from = (state == ST_SHIFT) ? addr_t'(idx + 4'd1) : '0;
      for (int n = NUM_CH - 1; n >= 0; n--) begin
         if (n >= int'(scan_from) &&
             !(valid[n] && last[n*DATA_W +: DATA_W] == shadow[n*DATA_W +: DATA_W])) begin
            found = 1'b1;
            sel   = addr_t'(n);
         end
      end
   end

   // An all-skipped scan never drives CS, so busy drops as soon as it reaches END.
   assign busy = (state != ST_IDLE) && !(state == ST_END && !sent);
`else
   always_comb begin
      found = 1'b1;
      sel   = '0;
      if (state == ST_SHIFT) begin
         found = (idx != addr_t'(NUM_CH - 1));
         sel   = addr_t'(idx + 4'd1);
      end
   end

   assign busy = (state != ST_IDLE);
`endif

   always_comb begin
      state_nx   = state;
      idx_nx     = idx;
      bit_cnt_nx = bit_cnt;
      case (state)
         ST_IDLE: begin
            if (load) begin
               state_nx = ST_NEXT_CH;
               idx_nx   = '0;
            end
         end
         ST_NEXT_CH: begin
            if (found) begin
               state_nx   = ST_CS_GAP;
               idx_nx     = sel;
               bit_cnt_nx = 5'(GAP_BITS - 1);
            end else begin
               state_nx = ST_END;
            end
         end
         ST_CS_GAP: begin
            if (fall) begin
               if (bit_cnt == '0) begin
                  state_nx   = ST_SHIFT;
                  bit_cnt_nx = 5'(FRAME_W - 1);
               end else begin
                  bit_cnt_nx = bit_cnt - 5'd1;
               end
            end
         end
         ST_SHIFT: begin
            if (fall) begin
               if (bit_cnt != '0) begin
                  bit_cnt_nx = bit_cnt - 5'd1;
               end else if (found) begin
                  state_nx   = ST_CS_GAP;
                  idx_nx     = sel;
                  bit_cnt_nx = 5'(GAP_BITS - 1);
               end else begin
                  state_nx = ST_END;
               end
            end
         end
         ST_END: begin
            if (load || pend) begin
               idx_nx = '0;
`ifdef SPI_DAC_MULTI_SKIP_UNCHANGED_EN
               state_nx = ST_NEXT_CH;
`else
               state_nx   = ST_CS_GAP;
               bit_cnt_nx = 5'(GAP_BITS - 1);
`endif
            end else begin
               state_nx = ST_IDLE;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         idx        <= '0;
         bit_cnt    <= '0;
         shadow     <= '0;
         pend_data  <= '0;
         pend       <= 1'b0;
         shift_q    <= '0;
         sck_int    <= 1'b0;
         spi_sck    <= 1'b0;
         spi_sdo    <= 1'b0;
         spi_dac_cs <= 1'b1;
      end else begin
         state   <= state_nx;
         idx     <= idx_nx;
         bit_cnt <= bit_cnt_nx;

         if (state == ST_IDLE && load)
            shadow <= data_in;
         else if (state == ST_END && (load || pend))
            shadow <= load ? data_in : pend_data;

         if (state != ST_IDLE && load)
            pend_data <= data_in;
         if (state == ST_END)
            pend <= 1'b0;
         else if (state != ST_IDLE && load)
            pend <= 1'b1;

         if (state == ST_CS_GAP)
            shift_q <= make_frame(CMD, idx, chan_data);
         else if (state == ST_SHIFT && fall)
            shift_q <= {shift_q[FRAME_W-2:0], 1'b0};

         if (!run)
            sck_int <= 1'b0;
         else if (rise)
            sck_int <= 1'b1;
         else if (fall)
            sck_int <= 1'b0;

         // Pins share one register stage so SDO and SCK keep their relative phase.
         spi_sck    <= (state == ST_SHIFT) && sck_int;
         spi_sdo    <= (state == ST_SHIFT) && shift_q[FRAME_W-1];
         spi_dac_cs <= (state != ST_SHIFT);
      end
   end

endmodule

// File: tb/tb_spi_dac_multi.sv
// Directed bench for spi_dac_multi: a 4ch/12b/div1 instance and a 2ch/8b/div3 instance.
module tb_spi_dac_multi;

   logic        clk = 1'b0;
   logic        reset;
   logic        load0, load1;
   logic [47:0] data0;
   logic [15:0] data1;
   logic [1:0]  busy_w, done_w, sck_w, sdo_w, cs_w;

   int checks = 0;
   int errors = 0;
   logic mon_en = 1'b0;

   always #5 clk = ~clk;

   spi_dac_multi #(.NUM_CH(4), .DATA_W(12), .CLK_DIV(1)) dut0 (
      .clk(clk), .reset(reset), .data_in(data0), .load(load0),
      .busy(busy_w[0]), .done(done_w[0]),
      .spi_sck(sck_w[0]), .spi_sdo(sdo_w[0]), .spi_dac_cs(cs_w[0])
   );

   spi_dac_multi #(.NUM_CH(2), .DATA_W(8), .CLK_DIV(3)) dut1 (
      .clk(clk), .reset(reset), .data_in(data1), .load(load1),
      .busy(busy_w[1]), .done(done_w[1]),
      .spi_sck(sck_w[1]), .spi_sdo(sdo_w[1]), .spi_dac_cs(cs_w[1])
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Pin monitor: frames decoded on SCK rising edges inside CS-low windows.
   logic [24:0] fq[$];
   logic [24:0] expq[$];
   logic [23:0] shreg[2];
   logic        p_sck[2], p_sdo[2], p_cs[2];
   int rises[2], lo_run[2], hi_run[2], cs_hi[2], gap_min[2];
   int sdo_bad[2], tim_bad[2], short_cnt[2], divs[2];
   int sck_bad;

   initial begin
      sck_bad = 0;
      divs[0] = 1;
      divs[1] = 3;
      for (int d = 0; d < 2; d++) begin
         shreg[d] = '0; p_sck[d] = 1'b0; p_sdo[d] = 1'b0; p_cs[d] = 1'b1;
         rises[d] = 0; lo_run[d] = 0; hi_run[d] = 0; cs_hi[d] = 1000; gap_min[d] = 1000;
         sdo_bad[d] = 0; tim_bad[d] = 0; short_cnt[d] = 0;
      end
      forever begin
         @(negedge clk);
         if (mon_en) begin
            for (int d = 0; d < 2; d++) begin
               if (p_cs[d] && !cs_w[d]) begin
                  if (cs_hi[d] < gap_min[d]) gap_min[d] = cs_hi[d];
                  rises[d] = 0; shreg[d] = '0; lo_run[d] = 0;
               end
               if (!cs_w[d] && sck_w[d] && !p_sck[d]) begin
                  shreg[d] = {shreg[d][22:0], sdo_w[d]};
                  rises[d]++;
                  if (sdo_w[d] !== p_sdo[d]) sdo_bad[d]++;
                  if (lo_run[d] != divs[d]) tim_bad[d]++;
               end
               if (!cs_w[d] && sck_w[d] && p_sck[d] && sdo_w[d] !== p_sdo[d]) sdo_bad[d]++;
               if (p_sck[d] && !sck_w[d] && hi_run[d] != divs[d]) tim_bad[d]++;
               if (cs_w[d] && sck_w[d]) sck_bad++;
               if (!p_cs[d] && cs_w[d]) begin
                  if (rises[d] == 24) fq.push_back({1'(d), shreg[d]});
                  else short_cnt[d]++;
               end
               hi_run[d] = sck_w[d] ? (p_sck[d] ? hi_run[d] + 1 : 1) : 0;
               lo_run[d] = (!sck_w[d] && !cs_w[d]) ? lo_run[d] + 1 : 0;
               cs_hi[d]  = cs_w[d] ? cs_hi[d] + 1 : 0;
               p_cs[d] = cs_w[d]; p_sck[d] = sck_w[d]; p_sdo[d] = sdo_w[d];
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start(input int d, input logic [47:0] v);
      if (d == 0) begin data0 = v; load0 = 1'b1; end
      else begin data1 = v[15:0]; load1 = 1'b1; end
      step();
      load0 = 1'b0;
      load1 = 1'b0;
   endtask

   task automatic wait_done(input int d, output int t);
      t = 0;
      do begin
         step();
         t++;
      end while (!done_w[d] && t < 2000);
      chk("done_seen", done_w[d], 1);
   endtask

   task automatic cmp_frames(input string tag, input int base);
      chk({tag, "_count"}, fq.size() - base, expq.size());
      for (int i = 0; i < expq.size() && base + i < fq.size(); i++)
         chk(tag, fq[base+i], expq[i]);
   endtask

   int t, base, ndone, busy_drop, short0;
   int done_t[3];

   initial begin
      reset = 1'b1; load0 = 1'b0; load1 = 1'b0; data0 = '0; data1 = '0;
      repeat (3) step();
      chk("rst_busy", busy_w[0], 0);
      chk("rst_done", done_w[0], 0);
      chk("rst_sck",  sck_w[0], 0);
      chk("rst_sdo",  sdo_w[0], 0);
      chk("rst_cs",   cs_w[0], 1);
      mon_en = 1'b1;
      reset  = 1'b0;
      step();

      // Four-channel scan
      base = fq.size();
      start(0, {12'hABC, 12'h789, 12'h456, 12'h123});
      chk("busy_rise", busy_w[0], 1);
      wait_done(0, t);
      chk("scan_len", t, 201);
      step();
      chk("busy_fall", busy_w[0], 0);
      repeat (4) step();
      expq = '{{1'b0, 24'h301230}, {1'b0, 24'h314560}, {1'b0, 24'h327890}, {1'b0, 24'h33ABC0}};
      cmp_frames("scan4", base);

      // 8-bit samples, CLK_DIV=3
      base = fq.size();
      start(1, {32'h0, 8'h5A, 8'hFF});
      wait_done(1, t);
      chk("scan_len_div3", t, 301);
      repeat (8) step();
      expq = '{{1'b1, 24'h30FF00}, {1'b1, 24'h315A00}};
      cmp_frames("div3", base);
      chk("div3_sdo_stable", sdo_bad[1], 0);
      chk("div3_sck_timing", tim_bad[1], 0);
      chk("div3_cs_gap", gap_min[1], 6);

      // Two loads during a scan: only the later one is sent, back to back
      base = fq.size();
      start(0, {12'h004, 12'h003, 12'h002, 12'h001});
      ndone = 0; busy_drop = 0;
      for (int c = 1; c <= 1000 && ndone < 2; c++) begin
         if (c == 20) begin data0 = {4{12'h111}}; load0 = 1'b1; end
         else if (c == 80) begin data0 = {4{12'h222}}; load0 = 1'b1; end
         else load0 = 1'b0;
         step();
         if (!busy_w[0]) busy_drop++;
         if (done_w[0]) begin ndone++; done_t[ndone] = c; end
      end
      load0 = 1'b0;
      chk("pend_ndone", ndone, 2);
      chk("pend_done1", done_t[1], 201);
`ifdef SPI_DAC_MULTI_SKIP_UNCHANGED_EN
      chk("pend_done2", done_t[2], 403);
`else
      chk("pend_done2", done_t[2], 402);
`endif
      chk("pend_busy_hold", busy_drop, 0);
      step();
      chk("pend_busy_fall", busy_w[0], 0);
      repeat (4) step();
      expq = '{{1'b0, 24'h300010}, {1'b0, 24'h310020}, {1'b0, 24'h320030}, {1'b0, 24'h330040},
               {1'b0, 24'h302220}, {1'b0, 24'h312220}, {1'b0, 24'h322220}, {1'b0, 24'h332220}};
      cmp_frames("pend", base);

      // Reset during bit 10 of channel 2
      base = fq.size();
      short0 = short_cnt[0];
      start(0, {12'h777, 12'h666, 12'h555, 12'h444});
      repeat (123) step();
      reset = 1'b1;
      step();
      chk("mid_rst_cs", cs_w[0], 1);
      chk("mid_rst_sck", sck_w[0], 0);
      chk("mid_rst_busy", busy_w[0], 0);
      reset = 1'b0;
      step();
      chk("mid_rst_frames", fq.size() - base, 2);
      chk("mid_rst_partial", short_cnt[0] - short0, 1);

      base = fq.size();
      start(0, {12'hA04, 12'hA03, 12'hA02, 12'hA01});
      wait_done(0, t);
      chk("restart_len", t, 201);
      repeat (4) step();
      expq = '{{1'b0, 24'h30A010}, {1'b0, 24'h31A020}, {1'b0, 24'h32A030}, {1'b0, 24'h33A040}};
      cmp_frames("restart", base);

`ifdef SPI_DAC_MULTI_SKIP_UNCHANGED_EN
      base = fq.size();
      start(0, {12'hA04, 12'hA03, 12'hA02, 12'hA01});
      chk("skip_busy1", busy_w[0], 1);
      step();
      chk("skip_busy2", busy_w[0], 0);
      chk("skip_done", done_w[0], 1);
      repeat (5) step();
      chk("skip_frames", fq.size() - base, 0);

      base = fq.size();
      start(0, {12'hA04, 12'hA03, 12'hB02, 12'hA01});
      wait_done(0, t);
      chk("skip_one_len", t, 51);
      repeat (4) step();
      expq = '{{1'b0, 24'h31B020}};
      cmp_frames("skip_one", base);
`endif

      chk("sdo_stable", sdo_bad[0], 0);
      chk("sck_timing", tim_bad[0], 0);
      chk("sck_only_cs_low", sck_bad, 0);
      chk("cs_gap", gap_min[0], 2);
      chk("div3_partial", short_cnt[1], 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
